// File: rtl/sha256_msg_padder_if.sv
// Handshake bundle between a message source, the SHA-256 padder and its block consumer.
// The master modport is the source/consumer side; the slave modport is the padder.
interface sha256_msg_padder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_bytes;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_idx;
   logic        out_block_last;
   logic        out_msg_last;

   modport master (
      output in_valid, in_data, in_bytes, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_block_last, out_msg_last
   );

   modport slave (
      input  in_valid, in_data, in_bytes, in_last, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_block_last, out_msg_last
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streams a byte-aligned big-endian message out as FIPS 180-4 padded 512-bit blocks,
// one 32-bit word per beat, tagged with its word index for sha256_lw.
module sha256_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   sha256_msg_padder_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_DATA   = 3'd0,
      ST_PAD80  = 3'd1,
      ST_ZERO   = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_LEN_LO = 3'd4
   } state_t;

   state_t            state_r;
   logic [3:0]        idx_r;
   logic [LEN_W-1:0]  len_r;
   logic              pend80_r;
   logic              out_valid_r;
   logic [31:0]       out_data_r;
   logic [3:0]        out_idx_r;
   logic              out_block_last_r;
   logic              out_msg_last_r;

   logic              fire_s;
   logic              in_ready_s;
   logic              accept_s;
   logic [2:0]        bytes_s;
   logic [3:0]        idx_next_s;
   logic [63:0]       len_ext_s;
   state_t            tail_state_s;

   // Final partial word: keep bytes 0..n-1, place 0x80 at byte n, zero the rest.
   function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [2:0] n);
      case (n)
         3'd0:    return 32'h8000_0000;
         3'd1:    return {data[31:24], 24'h80_0000};
         3'd2:    return {data[31:16], 16'h8000};
         3'd3:    return {data[31:8], 8'h80};
         default: return data;
      endcase
   endfunction

   // Handshake qualifiers, effective byte count and post-padding state selection.
   always_comb begin
      fire_s     = !out_valid_r || bus.out_ready;
      in_ready_s = reset_n && (state_r == ST_DATA) && fire_s && !clear;
      accept_s   = bus.in_valid && in_ready_s;
      idx_next_s = idx_r + 4'd1;
      if (bus.in_last && (bus.in_bytes < 3'd4)) begin
         bytes_s = bus.in_bytes;
      end else begin
         bytes_s = 3'd4;
      end
      len_ext_s              = 64'd0;
      len_ext_s[LEN_W-1:0]   = len_r;
      // Length words must occupy idx 14/15, so stop zero fill once the next slot is 14.
      if (idx_next_s == 4'd14) begin
         tail_state_s = ST_LEN_HI;
      end else begin
         tail_state_s = ST_ZERO;
      end
   end

   assign bus.in_ready       = in_ready_s;
   assign bus.out_valid      = out_valid_r;
   assign bus.out_data       = out_data_r;
   assign bus.out_idx        = out_idx_r;
   assign bus.out_block_last = out_block_last_r;
   assign bus.out_msg_last   = out_msg_last_r;

   // Padding FSM and the single output register; a new beat loads whenever the slot is free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r          <= ST_DATA;
         idx_r            <= 4'd0;
         len_r            <= '0;
         pend80_r         <= 1'b0;
         out_valid_r      <= 1'b0;
         out_data_r       <= 32'd0;
         out_idx_r        <= 4'd0;
         out_block_last_r <= 1'b0;
         out_msg_last_r   <= 1'b0;
      end else if (clear) begin
         state_r          <= ST_DATA;
         idx_r            <= 4'd0;
         len_r            <= '0;
         pend80_r         <= 1'b0;
         out_valid_r      <= 1'b0;
         out_data_r       <= 32'd0;
         out_idx_r        <= 4'd0;
         out_block_last_r <= 1'b0;
         out_msg_last_r   <= 1'b0;
      end else if (fire_s) begin
         out_valid_r      <= 1'b1;
         out_idx_r        <= idx_r;
         out_block_last_r <= (idx_r == 4'd15);
         out_msg_last_r   <= 1'b0;
         case (state_r)
            ST_DATA: begin
               if (accept_s) begin
                  idx_r <= idx_next_s;
                  len_r <= len_r + LEN_W'({bytes_s, 3'b000});
                  if (!bus.in_last) begin
                     out_data_r <= bus.in_data;
                  end else if (bytes_s == 3'd4) begin
                     out_data_r <= bus.in_data;
                     pend80_r   <= 1'b1;
                     state_r    <= ST_PAD80;
                  end else begin
                     out_data_r <= pad_last_word(bus.in_data, bytes_s);
                     state_r    <= tail_state_s;
                  end
               end else begin
                  out_valid_r <= 1'b0;
               end
            end
            ST_PAD80: begin
               out_data_r <= 32'h8000_0000;
               pend80_r   <= 1'b0;
               idx_r      <= idx_next_s;
               state_r    <= tail_state_s;
            end
            ST_ZERO: begin
               out_data_r <= 32'd0;
               idx_r      <= idx_next_s;
               state_r    <= tail_state_s;
            end
            ST_LEN_HI: begin
               out_data_r <= len_ext_s[63:32];
               idx_r      <= idx_next_s;
               state_r    <= ST_LEN_LO;
            end
            ST_LEN_LO: begin
               out_data_r     <= len_ext_s[31:0];
               out_msg_last_r <= 1'b1;
               idx_r          <= 4'd0;
               len_r          <= '0;
               pend80_r       <= 1'b0;
               state_r        <= ST_DATA;
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= ST_DATA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: directed messages push hand-computed padded
// beats into a queue; a monitor pops and compares every accepted output beat.
module tb_sha256_msg_padder;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  i;
      logic        bl;
      logic        ml;
   } beat_t;

   logic clk = 1'b0;
   logic reset_n;
   logic clear;
   bit   rnd_ready = 1'b0;
   beat_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic  stalled_prev = 1'b0;
   beat_t stall_snap;

   sha256_msg_padder_if bus();

   sha256_msg_padder #(.LEN_W(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic exp_beat(input logic [31:0] d, input logic [3:0] i, input logic ml);
      beat_t b;
      b.d  = d;
      b.i  = i;
      b.bl = (i == 4'd15);
      b.ml = ml;
      exp_q.push_back(b);
   endtask

   task automatic exp_zeros(input int from, input int to);
      for (int k = from; k <= to; k++) exp_beat(32'd0, 4'(k), 1'b0);
   endtask

   task automatic send(input logic [31:0] d, input logic [2:0] n, input logic last);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_bytes = n;
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic msg_abc();
      exp_beat(32'h6162_6380, 4'd0, 1'b0);
      exp_zeros(1, 14);
      exp_beat(32'h0000_0018, 4'd15, 1'b1);
      send(32'h6162_6300, 3'd3, 1'b1);
   endtask

   task automatic msg_56();
      for (int k = 0; k < 14; k++) exp_beat(32'hA000_0000 | 32'(k), 4'(k), 1'b0);
      exp_beat(32'h8000_0000, 4'd14, 1'b0);
      exp_beat(32'd0, 4'd15, 1'b0);
      exp_zeros(0, 14);
      exp_beat(32'h0000_01C0, 4'd15, 1'b1);
      for (int k = 0; k < 14; k++) send(32'hA000_0000 | 32'(k), 3'd4, (k == 13));
   endtask

   // Output-side ready: always accept, or a 50% random stall pattern.
   always @(posedge clk) begin
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: compare each accepted beat to the scoreboard and check stall stability.
   always @(negedge clk) begin
      beat_t got;
      got.d  = bus.out_data;
      got.i  = bus.out_idx;
      got.bl = bus.out_block_last;
      got.ml = bus.out_msg_last;
      if (stalled_prev && bus.out_valid === 1'b1) check("stall_hold", 64'(got), 64'(stall_snap));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(got), 64'd0);
         end else begin
            check($sformatf("beat_idx%0d", exp_q[0].i), 64'(got), 64'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
         check("in_ready_stalled", 64'(bus.in_ready), 64'd0);
         stalled_prev = 1'b1;
         stall_snap   = got;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   initial begin
      reset_n      = 1'b0;
      clear        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd0;
      bus.in_bytes = 3'd0;
      bus.in_last  = 1'b0;
      #12;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_idx", 64'(bus.out_idx), 64'd0);
      check("rst_block_last", 64'(bus.out_block_last), 64'd0);
      check("rst_msg_last", 64'(bus.out_msg_last), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      msg_abc();
      // Empty message
      exp_beat(32'h8000_0000, 4'd0, 1'b0);
      exp_zeros(1, 14);
      exp_beat(32'd0, 4'd15, 1'b1);
      send(32'hFFFF_FFFF, 3'd0, 1'b1);
      // Two bytes with junk in the masked bytes
      exp_beat(32'h6869_8000, 4'd0, 1'b0);
      exp_zeros(1, 14);
      exp_beat(32'h0000_0010, 4'd15, 1'b1);
      send(32'h6869_FFFF, 3'd2, 1'b1);
      // One byte with junk
      exp_beat(32'h4180_0000, 4'd0, 1'b0);
      exp_zeros(1, 14);
      exp_beat(32'h0000_0008, 4'd15, 1'b1);
      send(32'h41FF_FFFF, 3'd1, 1'b1);
      // 55 bytes: 0x80 lands at idx13, length fits in the same block
      for (int k = 0; k < 13; k++) exp_beat(32'hA000_0000 | 32'(k), 4'(k), 1'b0);
      exp_beat(32'h4142_4380, 4'd13, 1'b0);
      exp_beat(32'd0, 4'd14, 1'b0);
      exp_beat(32'h0000_01B8, 4'd15, 1'b1);
      for (int k = 0; k < 13; k++) send(32'hA000_0000 | 32'(k), 3'd4, 1'b0);
      send(32'h4142_4300, 3'd3, 1'b1);
      // 56 bytes: spills into a second block
      msg_56();
      // in_bytes above 4 on the last word acts as 4
      exp_beat(32'h1122_3344, 4'd0, 1'b0);
      exp_beat(32'h8000_0000, 4'd1, 1'b0);
      exp_zeros(2, 14);
      exp_beat(32'h0000_0020, 4'd15, 1'b1);
      send(32'h1122_3344, 3'd7, 1'b1);
      drain();

      rnd_ready = 1'b1;
      msg_56();
      msg_abc();
      drain();
      rnd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Clear in the middle of a block while a word is offered
      for (int k = 0; k < 7; k++) begin
         exp_beat(32'hC000_0000 | 32'(k), 4'(k), 1'b0);
         send(32'hC000_0000 | 32'(k), 3'd4, 1'b0);
      end
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD_BEEF;
      bus.in_bytes = 3'd4;
      bus.in_last  = 1'b0;
      @(negedge clk);
      check("clear_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("clear_out_valid", 64'(bus.out_valid), 64'd0);
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      msg_abc();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
